// File: rtl/pipeline_mem_wb_reg_pkg.sv
// Shared core encodings: write-back source selects and load funct3 codes.
package core_pkg;

   // Write-back source select encodings (ResultSrc)
   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_PC4 = 2'd2;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/pipeline_mem_wb_reg_load_align.sv
// Load data alignment: picks the byte/halfword addressed by the low
// address bits and sign- or zero-extends it to the full data width.
// Any funct3 that is not a byte/halfword load passes the word through.
module load_align
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [1:0]            offset_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Select the addressed byte and halfword (halfword ignores offset[0]).
   always_comb begin
      byte_sel = word_i[8*offset_i +: 8];
      half_sel = word_i[16*offset_i[1] +: 16];
   end

   // Extend the selected lane according to the load type.
   always_comb begin
      data_o = word_i;
      case (funct3_i)
         F3_LB:   data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         F3_LH:   data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/pipeline_mem_wb_reg.sv
// MEM/WB pipeline register with stall, flush (bubble), valid tracking,
// aligned load data, write-back result mux and retired-instruction counter.
module pipeline_mem_wb_reg
   import core_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH   = 5,
   parameter int RESULT_SRC_WIDTH = 2,
   parameter int COUNT_WIDTH      = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        StallW,
   input  logic                        FlushW,
   input  logic                        ValidM,
   input  logic [DATA_WIDTH-1:0]       ALUResultM,
   input  logic [DATA_WIDTH-1:0]       ReadDataM,
   input  logic [2:0]                  Funct3M,
   input  logic [REG_ADDR_WIDTH-1:0]   RdM,
   input  logic [DATA_WIDTH-1:0]       PCPlus4M,
   input  logic                        RegWriteM,
   input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
   output logic                        ValidW,
   output logic [DATA_WIDTH-1:0]       ALUResultW,
   output logic [DATA_WIDTH-1:0]       ReadDataW,
   output logic [REG_ADDR_WIDTH-1:0]   RdW,
   output logic [DATA_WIDTH-1:0]       PCPlus4W,
   output logic                        RegWriteW,
   output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW,
   output logic [DATA_WIDTH-1:0]       ResultW,
   output logic [COUNT_WIDTH-1:0]      InstretW
);

   logic [DATA_WIDTH-1:0] aligned_m;

   logic                        valid_q,   valid_d;
   logic [DATA_WIDTH-1:0]       alu_q,     alu_d;
   logic [DATA_WIDTH-1:0]       rdata_q,   rdata_d;
   logic [REG_ADDR_WIDTH-1:0]   rd_q,      rd_d;
   logic [DATA_WIDTH-1:0]       pc4_q,     pc4_d;
   logic                        regwr_q,   regwr_d;
   logic [RESULT_SRC_WIDTH-1:0] rsrc_q,    rsrc_d;
   logic [COUNT_WIDTH-1:0]      instret_q, instret_d;

   load_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_align (
      .word_i   (ReadDataM),
      .offset_i (ALUResultM[1:0]),
      .funct3_i (Funct3M),
      .data_o   (aligned_m)
   );

   // Next-state selection: flush beats stall, stall beats a normal load.
   always_comb begin
      valid_d   = valid_q;
      alu_d     = alu_q;
      rdata_d   = rdata_q;
      rd_d      = rd_q;
      pc4_d     = pc4_q;
      regwr_d   = regwr_q;
      rsrc_d    = rsrc_q;
      instret_d = instret_q;
      if (FlushW) begin
         valid_d = 1'b0;
         alu_d   = '0;
         rdata_d = '0;
         rd_d    = '0;
         pc4_d   = '0;
         regwr_d = 1'b0;
         rsrc_d  = '0;
      end else if (!StallW) begin
         valid_d = ValidM;
         alu_d   = ALUResultM;
         rdata_d = aligned_m;
         rd_d    = RdM;
         pc4_d   = PCPlus4M;
         // Writes to x0 and from bubbles never reach the register file.
         regwr_d = RegWriteM & ValidM & (RdM != '0);
         rsrc_d  = ResultSrcM;
         if (ValidM) begin
            instret_d = instret_q + COUNT_WIDTH'(1);
         end
      end
   end

   // W-stage state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         alu_q     <= '0;
         rdata_q   <= '0;
         rd_q      <= '0;
         pc4_q     <= '0;
         regwr_q   <= 1'b0;
         rsrc_q    <= '0;
         instret_q <= '0;
      end else begin
         valid_q   <= valid_d;
         alu_q     <= alu_d;
         rdata_q   <= rdata_d;
         rd_q      <= rd_d;
         pc4_q     <= pc4_d;
         regwr_q   <= regwr_d;
         rsrc_q    <= rsrc_d;
         instret_q <= instret_d;
      end
   end

   // Write-back result mux driven from the registered W fields.
   always_comb begin
      ResultW = '0;
      case (rsrc_q)
         RESULT_SRC_WIDTH'(RES_ALU): ResultW = alu_q;
         RESULT_SRC_WIDTH'(RES_MEM): ResultW = rdata_q;
         RESULT_SRC_WIDTH'(RES_PC4): ResultW = pc4_q;
         default:                    ResultW = '0;
      endcase
   end

   assign ValidW     = valid_q;
   assign ALUResultW = alu_q;
   assign ReadDataW  = rdata_q;
   assign RdW        = rd_q;
   assign PCPlus4W   = pc4_q;
   assign RegWriteW  = regwr_q;
   assign ResultSrcW = rsrc_q;
   assign InstretW   = instret_q;

endmodule

// File: tb/tb_pipeline_mem_wb_reg.sv
// Directed bench for the MEM/WB register: a reference model pushes the
// expected W state when inputs are driven, and it is popped and compared
// one edge later. A second instance uses a 4-bit counter to exercise wrap.
module tb_pipeline_mem_wb_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, StallW, FlushW, ValidM, RegWriteM;
   logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
   logic [2:0]  Funct3M;
   logic [4:0]  RdM;
   logic [1:0]  ResultSrcM;

   logic        a_ValidW, a_RegWriteW, b_ValidW, b_RegWriteW;
   logic [31:0] a_ALUResultW, a_ReadDataW, a_PCPlus4W, a_ResultW;
   logic [31:0] b_ALUResultW, b_ReadDataW, b_PCPlus4W, b_ResultW;
   logic [4:0]  a_RdW, b_RdW;
   logic [1:0]  a_ResultSrcW, b_ResultSrcW;
   logic [63:0] a_InstretW;
   logic [3:0]  b_InstretW;

   pipeline_mem_wb_reg dut (
      .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
      .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .Funct3M(Funct3M), .RdM(RdM),
      .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .ValidW(a_ValidW), .ALUResultW(a_ALUResultW), .ReadDataW(a_ReadDataW), .RdW(a_RdW),
      .PCPlus4W(a_PCPlus4W), .RegWriteW(a_RegWriteW), .ResultSrcW(a_ResultSrcW),
      .ResultW(a_ResultW), .InstretW(a_InstretW)
   );

   pipeline_mem_wb_reg #(.COUNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
      .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .Funct3M(Funct3M), .RdM(RdM),
      .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .ValidW(b_ValidW), .ALUResultW(b_ALUResultW), .ReadDataW(b_ReadDataW), .RdW(b_RdW),
      .PCPlus4W(b_PCPlus4W), .RegWriteW(b_RegWriteW), .ResultSrcW(b_ResultSrcW),
      .ResultW(b_ResultW), .InstretW(b_InstretW)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic        regwr;
      logic [1:0]  rsrc;
      logic [31:0] result;
      logic [63:0] instret;
   } exp_t;

   exp_t model;
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference load extension written from the byte-lane point of view.
   function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
      logic [31:0] sh;
      sh = w >> (off * 8);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b001:  return off[1] ? {{16{w[31]}}, w[31:16]} : {{16{w[15]}}, w[15:0]};
         3'b101:  return off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model with the driven inputs, push, clock, pop and compare.
   task automatic step(input string tag);
      exp_t n, e;
      n = model;
      if (rst) begin
         n = '0;
      end else if (FlushW) begin
         n.valid = 1'b0; n.alu = '0; n.rdata = '0; n.rd = '0;
         n.pc4 = '0; n.regwr = 1'b0; n.rsrc = '0;
      end else if (!StallW) begin
         n.valid = ValidM;
         n.alu   = ALUResultM;
         n.rdata = ref_align(ReadDataM, ALUResultM[1:0], Funct3M);
         n.rd    = RdM;
         n.pc4   = PCPlus4M;
         n.regwr = RegWriteM && ValidM && (RdM != 5'd0);
         n.rsrc  = ResultSrcM;
         if (ValidM) n.instret = model.instret + 64'd1;
      end
      case (n.rsrc)
         2'd0:    n.result = n.alu;
         2'd1:    n.result = n.rdata;
         2'd2:    n.result = n.pc4;
         default: n.result = 32'h0;
      endcase
      model = n;
      sb.push_back(n);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, ".ValidW"},     64'(a_ValidW),     64'(e.valid));
         chk({tag, ".ALUResultW"}, 64'(a_ALUResultW), 64'(e.alu));
         chk({tag, ".ReadDataW"},  64'(a_ReadDataW),  64'(e.rdata));
         chk({tag, ".RdW"},        64'(a_RdW),        64'(e.rd));
         chk({tag, ".PCPlus4W"},   64'(a_PCPlus4W),   64'(e.pc4));
         chk({tag, ".RegWriteW"},  64'(a_RegWriteW),  64'(e.regwr));
         chk({tag, ".ResultSrcW"}, 64'(a_ResultSrcW), 64'(e.rsrc));
         chk({tag, ".ResultW"},    64'(a_ResultW),    64'(e.result));
         chk({tag, ".InstretW"},   a_InstretW,        e.instret);
         chk({tag, ".w4.ResultW"}, 64'(b_ResultW),    64'(e.result));
         chk({tag, ".w4.RegWriteW"}, 64'(b_RegWriteW), 64'(e.regwr));
         chk({tag, ".w4.InstretW"}, 64'(b_InstretW),  64'(e.instret[3:0]));
         chk({tag, ".w4.fields"},
             {b_ValidW, b_ALUResultW[7:0], b_ReadDataW[7:0], b_RdW, b_PCPlus4W[7:0], b_ResultSrcW},
             {e.valid, e.alu[7:0], e.rdata[7:0], e.rd, e.pc4[7:0], e.rsrc});
         $display("step %-12s valid=%0d rd=%0d result=%08h instret=%0d",
                  tag, a_ValidW, a_RdW, a_ResultW, a_InstretW);
      end
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] exp;
   } align_t;

   align_t atab[5];
   logic [63:0] saved_instret;

   initial begin
      model = '0;
      atab[0] = '{3'b000, 2'd0, 32'hFFFFFFBB};
      atab[1] = '{3'b100, 2'd2, 32'h00000099};
      atab[2] = '{3'b001, 2'd2, 32'hFFFF8899};
      atab[3] = '{3'b101, 2'd0, 32'h0000AABB};
      atab[4] = '{3'b010, 2'd3, 32'h8899AABB};

      // Reset with every input non-zero
      rst = 1; StallW = 1; FlushW = 0; ValidM = 1; RegWriteM = 1;
      ALUResultM = 32'hDEADBEEF; ReadDataM = 32'h12345678; PCPlus4M = 32'h44;
      Funct3M = 3'b010; RdM = 5'd7; ResultSrcM = 2'd1;
      step("reset");
      chk("reset.instret0", a_InstretW, 64'd0);
      chk("reset.result0", 64'(a_ResultW), 64'd0);

      // First load
      rst = 0; StallW = 0; ValidM = 1; ALUResultM = 32'h10; RdM = 5'd5;
      RegWriteM = 1; ResultSrcM = 2'd0; PCPlus4M = 32'h14; ReadDataM = 32'h0;
      step("load1");
      chk("load1.alu", 64'(a_ALUResultW), 64'h10);
      chk("load1.regwr", 64'(a_RegWriteW), 64'd1);
      chk("load1.result", 64'(a_ResultW), 64'h10);
      chk("load1.instret", a_InstretW, 64'd1);

      // Load alignment table
      ReadDataM = 32'h8899AABB; ResultSrcM = 2'd1; RdM = 5'd9;
      for (int i = 0; i < 5; i++) begin
         Funct3M = atab[i].f3;
         ALUResultM = {30'h40, atab[i].off};
         step($sformatf("align%0d", i));
         chk($sformatf("align%0d.rdata", i), 64'(a_ReadDataW), 64'(atab[i].exp));
         chk($sformatf("align%0d.result", i), 64'(a_ResultW), 64'(atab[i].exp));
      end

      // Stall for three cycles while inputs move
      ResultSrcM = 2'd0; ALUResultM = 32'hA0; RdM = 5'd3; Funct3M = 3'b010;
      step("pre_stall");
      saved_instret = a_InstretW;
      StallW = 1;
      for (int i = 0; i < 3; i++) begin
         ALUResultM = 32'hB0 + 32'(i); RdM = 5'(10 + i); ResultSrcM = 2'(i);
         step($sformatf("stall%0d", i));
         chk($sformatf("stall%0d.alu_held", i), 64'(a_ALUResultW), 64'hA0);
         chk($sformatf("stall%0d.instret_held", i), a_InstretW, saved_instret);
      end
      StallW = 0; ALUResultM = 32'hC4; RdM = 5'd12; ResultSrcM = 2'd0;
      step("unstall");
      chk("unstall.alu", 64'(a_ALUResultW), 64'hC4);
      chk("unstall.instret", a_InstretW, saved_instret + 64'd1);

      // Flush together with stall
      saved_instret = a_InstretW;
      StallW = 1; FlushW = 1;
      step("flush_stall");
      chk("flush.valid", 64'(a_ValidW), 64'd0);
      chk("flush.regwr", 64'(a_RegWriteW), 64'd0);
      chk("flush.rd", 64'(a_RdW), 64'd0);
      chk("flush.result", 64'(a_ResultW), 64'd0);
      chk("flush.instret", a_InstretW, saved_instret);
      StallW = 0; FlushW = 0;

      // Write qualification
      saved_instret = a_InstretW;
      ValidM = 1; RegWriteM = 1; RdM = 5'd0;
      step("rd_zero");
      chk("rd_zero.regwr", 64'(a_RegWriteW), 64'd0);
      chk("rd_zero.instret", a_InstretW, saved_instret + 64'd1);
      saved_instret = a_InstretW;
      ValidM = 0; RdM = 5'd8;
      step("not_valid");
      chk("not_valid.regwr", 64'(a_RegWriteW), 64'd0);
      chk("not_valid.instret", a_InstretW, saved_instret);

      // Counter wrap on the 4-bit instance, PC+4 write-back
      rst = 1;
      step("reset2");
      rst = 0; ValidM = 1; ResultSrcM = 2'd2; PCPlus4M = 32'h104; RdM = 5'd1;
      for (int i = 0; i < 17; i++) step($sformatf("wrap%0d", i));
      chk("wrap.w4_instret", 64'(b_InstretW), 64'd1);
      chk("wrap.instret64", a_InstretW, 64'd17);
      chk("wrap.result_pc4", 64'(a_ResultW), 64'h104);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
